lsu: RTL and testbench
======================

# lsu

Load/store stage directly downstream of the execute unit. It takes the execute result as an effective address (or as a plain result for non-memory instructions) and performs one aligned access on a 64-bit data-memory bus: byte-lane steering and write masks for stores, lane extraction and sign/zero extension for loads. It then hands the writeback value to the next stage. Both sides use a valid/ready handshake, and the block holds at most one instruction at a time.

## Interface
- `CPU_WIDTH`, default 64: datapath width. Only 64 is supported; the bus is fixed at 64 bits.
- `i_clk`  in  1  clock; all state updates on the rising edge.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  upstream has an instruction.
- `o_ready`  out  1  block can accept; equals (state == IDLE).
- `i_mem_en`  in  1  1 = load/store, 0 = pass `i_addr` through as the result.
- `i_lsu_opt`  in  4  bit3 = store; bit2 = unsigned load; bits1:0 = size (0 B, 1 H, 2 W, 3 D).
- `i_addr`  in  CPU_WIDTH  execute result (effective address or pass-through value).
- `i_wdata`  in  CPU_WIDTH  store data (rs2).
- `o_valid`  out  1  result available.
- `i_ready`  in  1  downstream accepts.
- `o_lsu_res`  out  CPU_WIDTH  writeback value.
- `o_misalign`  out  1  qualifies `o_valid`; the access was misaligned and no bus access was issued.
- `o_mem_req`  out  1  bus request.
- `o_mem_we`  out  1  1 = write.
- `o_mem_addr`  out  CPU_WIDTH  address with bits 2:0 forced to 0.
- `o_mem_wdata`  out  64  store data shifted into its byte lanes.
- `o_mem_wmask`  out  8  byte enables.
- `i_mem_gnt`  in  1  request accepted this cycle.
- `i_mem_rvalid`  in  1  read data valid; asserted no earlier than the cycle after `gnt`.
- `i_mem_rdata`  in  64  read data for the full 8-byte word.

## Operation
- The input is captured on handshake `i_valid & o_ready`. Address, opt, wdata and mem_en are registered. Nothing is sampled from the input outside the handshake.
- Misaligned when `size != 0` and `addr[size-1:0] != 0`.
- FSM states: IDLE, REQ, WAIT, RESP.
  - IDLE, on handshake:
    - `!mem_en` goes to RESP with result = `i_addr`.
    - Misaligned goes to RESP with result = 0 and misalign = 1.
    - Otherwise goes to REQ.
  - REQ: `o_mem_req` = 1 and the bus fields stay stable until `i_mem_gnt`.
    - Store with `gnt` goes to RESP, result = 0.
    - Load with `gnt` goes to WAIT.
  - WAIT: on `i_mem_rvalid`, latch the extended load data and go to RESP.
  - RESP: `o_valid` = 1. Result and misalign stay stable until `i_ready`, then go to IDLE.
- A new input is accepted no earlier than the cycle after RESP completes, because `o_ready` is low in RESP.
- Store lanes: `wdata << (8*addr[2:0])`.
  - `wmask = {0x01,0x03,0x0F,0xFF}[size] << addr[2:0]`.
  - `o_mem_we` = 1.
- Load lanes: `rdata >> (8*addr[2:0])`, truncated to the size, then sign-extended, or zero-extended when bit2 = 1. Size D ignores bit2.
- `o_mem_we`, `wmask` and `wdata` are 0 whenever `o_mem_req` = 0.
- `i_mem_rvalid` outside WAIT is ignored, as is `gnt` outside REQ.

## Timing
- Reset values:
  - State IDLE, so `o_ready` = 1.
  - `o_valid`, `o_misalign`, `o_mem_req` and `o_mem_we` = 0.
  - `o_lsu_res`, `o_mem_addr`, `o_mem_wdata` and `o_mem_wmask` = 0.
- Reset mid-operation (in REQ, WAIT or RESP) returns to IDLE on the next edge. The request is dropped, and a late `rvalid` is discarded.
- Latency from handshake at cycle T, all responders immediate:
  - Pass-through or misaligned: `o_valid` at T+1.
  - Store: `req` at T+1, `gnt` at T+1, `o_valid` at T+2.
  - Load: `req` and `gnt` at T+1, `rvalid` at T+2, `o_valid` at T+3.
- Each cycle without `gnt` or `rvalid` adds one cycle. Each cycle of `i_ready` = 0 holds RESP.
- All outputs are registered or decoded from state only. There is no combinational path from `i_valid` or `i_mem_*` to `o_ready`, `o_valid` or `o_mem_req`.

## Test plan
- Pass-through: `mem_en`=0, `addr`=0x1234, `i_ready`=1. Expect `o_valid` at T+1 with result 0x1234, and `o_mem_req` never asserted.
- LB sign extension: `addr`=0x80000003, `rdata`=0x00000000_80FF0000, opt=0b0000. Expect `o_mem_addr`=0x80000000 and result 0xFFFFFFFF_FFFFFF80. The same access with LBU (opt=0b0100) gives 0x80.
- SH lane steering: `addr`=0x80000006, `wdata`=0xABCD, opt=0b1001. Expect `wmask`=0xC0 and `wdata`=0xABCD0000_00000000. `gnt` delayed 3 cycles: `req` and fields held stable, and `o_valid` arrives one cycle after `gnt`.
- Misaligned LW: `addr`=0x80000002. Expect `o_valid` at T+1 with `o_misalign`=1, result 0, and no `o_mem_req`.
- Backpressure and reset: LD completes while `i_ready`=0 for 4 cycles. `o_valid` and result stay stable, and `o_ready` stays 0. Then a second load has `i_rst` pulsed in WAIT followed by a stray `rvalid`. Expect IDLE, `o_valid`=0, and the next pass-through op to complete normally.

Source files
------------

// File: rtl/lsu.sv
// Load/store stage: one aligned 64-bit data-memory access per instruction,
// with byte-lane steering for stores and lane extraction/extension for loads.
module lsu #(
  parameter int CPU_WIDTH = 64
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic                 i_mem_en,
  input  logic [3:0]           i_lsu_opt,
  input  logic [CPU_WIDTH-1:0] i_addr,
  input  logic [CPU_WIDTH-1:0] i_wdata,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [CPU_WIDTH-1:0] o_lsu_res,
  output logic                 o_misalign,
  output logic                 o_mem_req,
  output logic                 o_mem_we,
  output logic [CPU_WIDTH-1:0] o_mem_addr,
  output logic [63:0]          o_mem_wdata,
  output logic [7:0]           o_mem_wmask,
  input  logic                 i_mem_gnt,
  input  logic                 i_mem_rvalid,
  input  logic [63:0]          i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_r;
  logic [2:0]  off_r;
  logic [3:0]  opt_r;
  logic        misalign_s;
  logic [7:0]  mask_base_s;
  logic [7:0]  wmask_s;
  logic [63:0] wdata_lane_s;

  // Picks the addressed lane out of the read word, then sign/zero extends it.
  function automatic logic [63:0] load_extend(input logic [63:0] rdata,
                                              input logic [2:0]  off,
                                              input logic [2:0]  ext);
    logic [63:0] sh;
    logic [63:0] res;
    sh = rdata >> {off, 3'b000};
    case (ext[1:0])
      2'd0:    res = ext[2] ? {56'd0, sh[7:0]}  : {{56{sh[7]}},  sh[7:0]};
      2'd1:    res = ext[2] ? {48'd0, sh[15:0]} : {{48{sh[15]}}, sh[15:0]};
      2'd2:    res = ext[2] ? {32'd0, sh[31:0]} : {{32{sh[31]}}, sh[31:0]};
      default: res = sh;
    endcase
    return res;
  endfunction

  assign o_ready   = (state_r == IDLE);
  assign o_valid   = (state_r == RESP);
  assign o_mem_req = (state_r == REQ);

  always_comb begin
    misalign_s  = 1'b0;
    mask_base_s = 8'h01;
    case (i_lsu_opt[1:0])
      2'd0: begin misalign_s = 1'b0;          mask_base_s = 8'h01; end
      2'd1: begin misalign_s = i_addr[0];     mask_base_s = 8'h03; end
      2'd2: begin misalign_s = |i_addr[1:0];  mask_base_s = 8'h0F; end
      default: begin misalign_s = |i_addr[2:0]; mask_base_s = 8'hFF; end
    endcase
  end

  assign wmask_s      = mask_base_s << i_addr[2:0];
  assign wdata_lane_s = i_wdata << {i_addr[2:0], 3'b000};

  // Bus fields are loaded on entry to REQ and cleared as soon as the grant lands.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_r     <= IDLE;
      off_r       <= 3'd0;
      opt_r       <= 4'd0;
      o_lsu_res   <= '0;
      o_misalign  <= 1'b0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= '0;
      o_mem_wdata <= 64'd0;
      o_mem_wmask <= 8'd0;
    end else begin
      case (state_r)
        IDLE: begin
          if (i_valid) begin
            off_r <= i_addr[2:0];
            opt_r <= i_lsu_opt;
            if (!i_mem_en) begin
              o_lsu_res  <= i_addr;
              o_misalign <= 1'b0;
              state_r    <= RESP;
            end else if (misalign_s) begin
              o_lsu_res  <= '0;
              o_misalign <= 1'b1;
              state_r    <= RESP;
            end else begin
              o_mem_addr  <= {i_addr[CPU_WIDTH-1:3], 3'b000};
              o_mem_we    <= i_lsu_opt[3];
              o_mem_wdata <= i_lsu_opt[3] ? wdata_lane_s : 64'd0;
              o_mem_wmask <= i_lsu_opt[3] ? wmask_s : 8'd0;
              state_r     <= REQ;
            end
          end else begin
            state_r <= IDLE;
          end
        end
        REQ: begin
          if (i_mem_gnt) begin
            o_mem_we    <= 1'b0;
            o_mem_wdata <= 64'd0;
            o_mem_wmask <= 8'd0;
            if (opt_r[3]) begin
              o_lsu_res  <= '0;
              o_misalign <= 1'b0;
              state_r    <= RESP;
            end else begin
              state_r <= WAIT;
            end
          end else begin
            state_r <= REQ;
          end
        end
        WAIT: begin
          if (i_mem_rvalid) begin
            o_lsu_res  <= load_extend(i_mem_rdata, off_r, opt_r[2:0]);
            o_misalign <= 1'b0;
            state_r    <= RESP;
          end else begin
            state_r <= WAIT;
          end
        end
        RESP: begin
          if (i_ready) begin
            o_misalign <= 1'b0;
            state_r    <= IDLE;
          end else begin
            state_r <= RESP;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu.sv
// Directed bench for lsu: pass-through, loads, stores, misalignment,
// backpressure and mid-operation reset, against hand-computed values.
module tb_lsu;

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_valid = 1'b0;
  logic        o_ready;
  logic        i_mem_en = 1'b0;
  logic [3:0]  i_lsu_opt = 4'd0;
  logic [63:0] i_addr = 64'd0;
  logic [63:0] i_wdata = 64'd0;
  logic        o_valid;
  logic        i_ready = 1'b1;
  logic [63:0] o_lsu_res;
  logic        o_misalign;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [63:0] o_mem_addr;
  logic [63:0] o_mem_wdata;
  logic [7:0]  o_mem_wmask;
  logic        i_mem_gnt = 1'b1;
  logic        i_mem_rvalid = 1'b0;
  logic [63:0] i_mem_rdata = 64'd0;

  int checks = 0;
  int errors = 0;

  lsu #(.CPU_WIDTH(64)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_mem_en(i_mem_en), .i_lsu_opt(i_lsu_opt), .i_addr(i_addr), .i_wdata(i_wdata),
    .o_valid(o_valid), .i_ready(i_ready), .o_lsu_res(o_lsu_res), .o_misalign(o_misalign),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_wmask(o_mem_wmask), .i_mem_gnt(i_mem_gnt),
    .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_pass(input string tag, input logic [63:0] val);
    i_valid = 1'b1; i_mem_en = 1'b0; i_lsu_opt = 4'd0; i_addr = val; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_res"}, o_lsu_res, val);
    check({tag, "_noreq"}, o_mem_req, 0);
    check({tag, "_busy"}, o_ready, 0);
    tick();
    check({tag, "_idle"}, o_ready, 1);
    check({tag, "_vdone"}, o_valid, 0);
  endtask

  task automatic do_load(input string tag, input logic [63:0] addr, input logic [3:0] opt,
                         input logic [63:0] rdata, input logic [63:0] exp, input int hold);
    logic [63:0] exp_addr;
    exp_addr = addr & ~64'h7;
    i_mem_gnt = 1'b1; i_ready = (hold == 0);
    i_valid = 1'b1; i_mem_en = 1'b1; i_lsu_opt = opt; i_addr = addr;
    tick();
    i_valid = 1'b0;
    check({tag, "_req"}, o_mem_req, 1);
    check({tag, "_addr"}, o_mem_addr, exp_addr);
    check({tag, "_we"}, o_mem_we, 0);
    check({tag, "_mask"}, o_mem_wmask, 0);
    tick();
    check({tag, "_wait_req"}, o_mem_req, 0);
    check({tag, "_wait_valid"}, o_valid, 0);
    i_mem_rvalid = 1'b1; i_mem_rdata = rdata;
    tick();
    i_mem_rvalid = 1'b0; i_mem_rdata = 64'd0;
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_res"}, o_lsu_res, exp);
    check({tag, "_mis"}, o_misalign, 0);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({tag, "_hold_valid"}, o_valid, 1);
      check({tag, "_hold_res"}, o_lsu_res, exp);
      check({tag, "_hold_ready"}, o_ready, 0);
    end
    i_ready = 1'b1;
    tick();
    check({tag, "_idle"}, o_ready, 1);
  endtask

  task automatic do_store(input string tag, input logic [63:0] addr, input logic [3:0] opt,
                          input logic [63:0] wdata, input logic [63:0] exp_wd,
                          input logic [7:0] exp_mask, input int gnt_delay);
    logic [63:0] exp_addr;
    exp_addr = addr & ~64'h7;
    i_mem_gnt = (gnt_delay == 0); i_ready = 1'b1;
    i_valid = 1'b1; i_mem_en = 1'b1; i_lsu_opt = opt; i_addr = addr; i_wdata = wdata;
    tick();
    i_valid = 1'b0;
    check({tag, "_req"}, o_mem_req, 1);
    check({tag, "_we"}, o_mem_we, 1);
    check({tag, "_addr"}, o_mem_addr, exp_addr);
    check({tag, "_wdata"}, o_mem_wdata, exp_wd);
    check({tag, "_mask"}, o_mem_wmask, exp_mask);
    for (int i = 0; i < gnt_delay; i++) begin
      tick();
      check({tag, "_hold_req"}, o_mem_req, 1);
      check({tag, "_hold_wdata"}, o_mem_wdata, exp_wd);
      check({tag, "_hold_mask"}, o_mem_wmask, exp_mask);
      check({tag, "_hold_valid"}, o_valid, 0);
    end
    i_mem_gnt = 1'b1;
    tick();
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_res"}, o_lsu_res, 0);
    check({tag, "_req_off"}, o_mem_req, 0);
    check({tag, "_we_off"}, o_mem_we, 0);
    check({tag, "_mask_off"}, o_mem_wmask, 0);
    check({tag, "_wdata_off"}, o_mem_wdata, 0);
    tick();
    check({tag, "_idle"}, o_ready, 1);
  endtask

  task automatic do_misalign(input string tag, input logic [63:0] addr, input logic [3:0] opt);
    i_valid = 1'b1; i_mem_en = 1'b1; i_lsu_opt = opt; i_addr = addr; i_ready = 1'b1;
    tick();
    i_valid = 1'b0;
    check({tag, "_valid"}, o_valid, 1);
    check({tag, "_mis"}, o_misalign, 1);
    check({tag, "_res"}, o_lsu_res, 0);
    check({tag, "_noreq"}, o_mem_req, 0);
    tick();
    check({tag, "_mis_clr"}, o_misalign, 0);
    check({tag, "_idle"}, o_ready, 1);
  endtask

  initial begin
    tick();
    tick();
    check("rst_ready", o_ready, 1);
    check("rst_valid", o_valid, 0);
    check("rst_mis", o_misalign, 0);
    check("rst_req", o_mem_req, 0);
    check("rst_we", o_mem_we, 0);
    check("rst_res", o_lsu_res, 0);
    check("rst_addr", o_mem_addr, 0);
    check("rst_wdata", o_mem_wdata, 0);
    check("rst_mask", o_mem_wmask, 0);
    i_rst = 1'b0;
    tick();

    do_pass("pass", 64'h1234);

    do_load("lb",  64'h8000_0003, 4'b0000, 64'h0000_0000_80FF_0000, 64'hFFFF_FFFF_FFFF_FF80, 0);
    do_load("lbu", 64'h8000_0003, 4'b0100, 64'h0000_0000_80FF_0000, 64'h0000_0000_0000_0080, 0);
    do_load("lh",  64'h8000_0016, 4'b0001, 64'hFEDC_BA98_7654_3210, 64'hFFFF_FFFF_FFFF_FEDC, 0);
    do_load("lwu", 64'h8000_0024, 4'b0110, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_FEDC_BA98, 0);
    do_load("lw",  64'h8000_0020, 4'b0010, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_7654_3210, 0);
    do_load("lbu7", 64'h8000_0007, 4'b0100, 64'hFEDC_BA98_7654_3210, 64'h0000_0000_0000_00FE, 0);

    do_store("sh", 64'h8000_0006, 4'b1001, 64'h0000_0000_0000_ABCD, 64'hABCD_0000_0000_0000, 8'hC0, 3);
    do_store("sb", 64'h8000_0105, 4'b1000, 64'h1122_3344_5566_77EF, 64'h6677_EF00_0000_0000, 8'h20, 0);
    do_store("sw", 64'h8000_0204, 4'b1010, 64'h0000_0000_DEAD_BEEF, 64'hDEAD_BEEF_0000_0000, 8'hF0, 1);
    do_store("sd", 64'h8000_0308, 4'b1011, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 8'hFF, 0);

    do_misalign("mis_lw", 64'h8000_0002, 4'b0010);
    do_misalign("mis_sd", 64'h8000_0004, 4'b1011);
    do_misalign("mis_lh", 64'h8000_0001, 4'b0001);

    do_load("ld_bp", 64'h8000_0008, 4'b0111, 64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 4);

    // Reset while waiting for read data, then a stray rvalid that must be dropped.
    i_mem_gnt = 1'b1;
    i_valid = 1'b1; i_mem_en = 1'b1; i_lsu_opt = 4'b0011; i_addr = 64'h8000_0010;
    tick();
    i_valid = 1'b0;
    check("rst_mid_req", o_mem_req, 1);
    tick();
    check("rst_mid_wait", o_mem_req, 0);
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    check("rst_mid_ready", o_ready, 1);
    check("rst_mid_valid", o_valid, 0);
    check("rst_mid_req_off", o_mem_req, 0);
    i_mem_rvalid = 1'b1; i_mem_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    i_mem_rvalid = 1'b0;
    check("stray_valid", o_valid, 0);
    check("stray_ready", o_ready, 1);
    do_pass("pass2", 64'hDEAD);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
